data_mem_responder: RTL

//  Responder end of the load/store request interface driven by the memory stage: accepts

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/dmem_ram.sv | 30 +++
 rtl/data_mem_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, byte-strobe
// encodings and the read-lane extraction function.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] STRB_B0 = 4'b0001;
  localparam logic [3:0] STRB_B1 = 4'b0010;
  localparam logic [3:0] STRB_B2 = 4'b0100;
  localparam logic [3:0] STRB_B3 = 4'b1000;
  localparam logic [3:0] STRB_H0 = 4'b0011;
  localparam logic [3:0] STRB_H1 = 4'b0110;
  localparam logic [3:0] STRB_H2 = 4'b1100;
  localparam logic [3:0] STRB_W  = 4'b1111;

  function automatic logic [1:0] low_lane(input logic [3:0] strb);
    if (strb[0])      low_lane = 2'd0;
    else if (strb[1]) low_lane = 2'd1;
    else if (strb[2]) low_lane = 2'd2;
    else              low_lane = 2'd3;
  endfunction

  // Single bytes are sign-extended; anything wider takes two lanes from the lowest set
  // lane, and the shift naturally zero-fills whatever lies beyond lane 3.
  function automatic logic [15:0] lane_select(input logic [31:0] word, input logic [3:0] strb);
    logic [31:0] shifted;
    shifted = word >> {low_lane(strb), 3'b000};
    case (strb)
      4'b0000:                            lane_select = 16'h0000;
      STRB_B0, STRB_B1, STRB_B2, STRB_B3: lane_select = {{8{shifted[7]}}, shifted[7:0]};
      STRB_H0, STRB_H1, STRB_H2:          lane_select = shifted[15:0];
      default:                            lane_select = shifted[15:0];
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the memory stage (master) and the responder (slave).
interface data_mem_responder_if #(
  parameter int XLEN   = 32,
  parameter int RESP_W = 16
);
  logic              r_v;
  logic              w_v;
  logic [XLEN-1:0]   req_adr;
  logic [XLEN-1:0]   req_data;
  logic [3:0]        req_strobe;
  logic              hit;
  logic [RESP_W-1:0] mem_res;
  logic              busy;
  logic              err;

  modport master (
    output r_v, w_v, req_adr, req_data, req_strobe,
    input  hit, mem_res, busy, err
  );

  modport slave (
    input  r_v, w_v, req_adr, req_data, req_strobe,
    output hit, mem_res, busy, err
  );
endinterface

// File: rtl/dmem_ram.sv
// Word-organised data store: one synchronous byte-enabled write port and one
// asynchronous read port.
module dmem_ram #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [XLEN/8-1:0]              be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [XLEN-1:0]                wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [XLEN-1:0]                rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset; clearing it would forbid block-RAM mapping and its
  // contents are meant to survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the memory-stage load/store bus: byte-enabled writes into the local
// RAM, fixed-latency halfword read responses, and err pulses for refused requests.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [XLEN:0] ADR_LIMIT = (XLEN+1)'(4 * DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [3:0]        strb_q, strb_d;
  logic              oor_q, oor_d;
  logic              err_q, err_d;
  logic [RESP_W-1:0] mem_res_q, mem_res_d;

  logic              req_oor;
  logic              ram_we;
  logic [XLEN-1:0]   ram_rdata;

  assign req_oor = {1'b0, bus.req_adr} >= ADR_LIMIT;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    strb_d    = strb_q;
    oor_d     = oor_q;
    err_d     = 1'b0;
    mem_res_d = mem_res_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.r_v && bus.w_v) begin
          err_d = 1'b1;
        end else if (bus.r_v) begin
          idx_d   = bus.req_adr[AW+1:2];
          strb_d  = bus.req_strobe;
          oor_d   = req_oor;
          err_d   = req_oor;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end else if (bus.w_v) begin
          ram_we = !req_oor && !rst;
          err_d  = req_oor;
        end
      end
      WAIT: begin
        err_d = bus.r_v || bus.w_v;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        err_d     = bus.r_v || bus.w_v;
        mem_res_d = oor_q ? '0 : RESP_W'(lane_select(ram_rdata, strb_q));
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      strb_q    <= '0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      mem_res_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      strb_q    <= strb_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      mem_res_q <= mem_res_d;
    end
  end

  dmem_ram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (bus.req_strobe),
    .waddr (bus.req_adr[AW+1:2]),
    .wdata (bus.req_data),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  assign bus.hit     = (state_q == RESP);
  assign bus.busy    = (state_q != IDLE);
  assign bus.err     = err_q;
  assign bus.mem_res = mem_res_d;

endmodule
